pc_branch_unit: RTL and testbench

- Consumes the ALU's branch flags (notequal, lessthan) and shift-carry output (sc_o) and produces the next program counter and the registered sc_in.
- Sequences the core through the start/done handshake with the test bench.
- Resolves branch targets through a loadable 16-entry target lookup table indexed by the instruction's 4-bit immediate.
- Sits between the decoder/ALU and instruction memory.

---
 rtl/pc_branch_unit_pkg.sv | 22 ++
 rtl/pc_branch_unit_if.sv | 44 ++++
 rtl/pc_branch_unit_branch_lut.sv | 34 +++
 rtl/pc_branch_unit.sv | 123 ++++++++++++
 tb/tb_pc_branch_unit.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_branch_unit_pkg.sv
// Shared definitions for the program-counter / branch unit:
// FSM state encoding, branch-type encodings and default widths.
package pc_branch_unit_pkg;

    // Default program counter width (1024-instruction ROM)
    localparam int PC_W_DEF      = 10;
    // Branch target table size and its index width (instruction immediate)
    localparam int LUT_DEPTH_DEF = 16;
    localparam int LUT_IDX_W     = 4;

    // Branch type encodings carried on br_type
    localparam logic BR_NEQ = 1'b0;
    localparam logic BR_LT  = 1'b1;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pc_branch_unit_if.sv
// Bundle of the branch unit's control, flag, table-load and PC signals.
// Handshake: start is a level request from the bench side; the unit
// answers with running (high while executing) and done (high after a
// halt until the next start). There is no ready/valid pairing: a start
// seen in IDLE or DONE is accepted on the very next rising edge, and a
// start seen in RUN is ignored.
// The master modport is the bench/decoder side, the slave is the unit.
interface pc_branch_unit_if
    import pc_branch_unit_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
);
    logic                 start;
    logic                 halt;
    logic                 br_en;
    logic                 br_type;
    logic                 notequal;
    logic                 lessthan;
    logic [LUT_IDX_W-1:0] target_idx;
    logic                 sc_wr;
    logic                 sc_o;
    logic                 lut_we;
    logic [LUT_IDX_W-1:0] lut_addr;
    logic [PC_W-1:0]      lut_data;
    logic [PC_W-1:0]      prog_ctr;
    logic                 sc_in;
    logic                 running;
    logic                 done;
    logic [15:0]          cycle_count;
    state_t               state_dbg;

    modport master (
        output start, halt, br_en, br_type, notequal, lessthan, target_idx,
               sc_wr, sc_o, lut_we, lut_addr, lut_data,
        input  prog_ctr, sc_in, running, done, cycle_count, state_dbg
    );

    modport slave (
        input  start, halt, br_en, br_type, notequal, lessthan, target_idx,
               sc_wr, sc_o, lut_we, lut_addr, lut_data,
        output prog_ctr, sc_in, running, done, cycle_count, state_dbg
    );

endinterface

// File: rtl/pc_branch_unit_branch_lut.sv
// Branch target table: LUT_DEPTH x PC_W register file with asynchronous
// clear, one synchronous write port and one combinational read port.
module pc_branch_unit_branch_lut
    import pc_branch_unit_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int LUT_DEPTH = LUT_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [LUT_IDX_W-1:0] waddr,
    input  logic [PC_W-1:0]      wdata,
    input  logic [LUT_IDX_W-1:0] raddr,
    output logic [PC_W-1:0]      rdata
);

    logic [PC_W-1:0] mem [LUT_DEPTH];

    // Table storage: cleared on reset, written one entry per edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Target lookup is combinational so a branch lands in one cycle
    assign rdata = mem[raddr];

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter and branch resolution unit.
// IDLE -> RUN on start; RUN advances or branches one instruction per
// cycle until halt; DONE holds results until the next start.
// Optional build macro: PC_CYCLE_COUNT_EN adds a saturating RUN-cycle
// counter on cycle_count; without it cycle_count reads zero.
module pc_branch_unit
    import pc_branch_unit_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int LUT_DEPTH = LUT_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    pc_branch_unit_if.slave  bus
);

    state_t          state;
    logic [PC_W-1:0] pc_q;
    logic            sc_q;
    logic            running_q;
    logic            done_q;
    logic            lut_wr;
    logic [PC_W-1:0] lut_target;
    logic            taken;

    // The table may only be reloaded between programs
    assign lut_wr = (state == IDLE) && bus.lut_we;

    pc_branch_unit_branch_lut #(
        .PC_W      (PC_W),
        .LUT_DEPTH (LUT_DEPTH)
    ) u_branch_lut (
        .clk   (clk),
        .reset (reset),
        .we    (lut_wr),
        .waddr (bus.lut_addr),
        .wdata (bus.lut_data),
        .raddr (bus.target_idx),
        .rdata (lut_target)
    );

    // Flags only matter for a branch; br_type picks which flag decides
    assign taken = bus.br_en &&
                   ((bus.br_type == BR_LT) ? bus.lessthan : bus.notequal);

    // Sequencer, program counter and shift-carry register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pc_q      <= '0;
            sc_q      <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pc_q <= '0;
                    if (bus.start) begin
                        state     <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    // Carry capture is independent of halt and branch
                    if (bus.sc_wr) begin
                        sc_q <= bus.sc_o;
                    end
                    if (bus.halt) begin
                        state     <= DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (taken) begin
                        pc_q <= lut_target;
                    end else begin
                        pc_q <= pc_q + PC_W'(1);
                    end
                end
                DONE: begin
                    if (bus.start) begin
                        state     <= RUN;
                        pc_q      <= '0;
                        running_q <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    pc_q      <= '0;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_CYCLE_COUNT_EN
    logic [15:0] cnt_q;

    // Counts every RUN edge including the halting one, saturating
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state == RUN) begin
            if (cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end else if (bus.start) begin
            cnt_q <= '0;
        end
    end

    assign bus.cycle_count = cnt_q;
`else
    assign bus.cycle_count = 16'h0000;
`endif

    assign bus.prog_ctr  = pc_q;
    assign bus.sc_in     = sc_q;
    assign bus.running   = running_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: directed vector table, hand-written
// reset/counter sequences and random stimulus against a reference model.
module tb_pc_branch_unit;
    import pc_branch_unit_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pc_branch_unit_if bus ();

    pc_branch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks;
    int failures;

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 executing, 2 finished
    int m_mode;
    int m_pc;
    int m_sc;
    int m_cnt;
    int m_lut [16];

    function automatic void model_reset();
        m_mode = 0;
        m_pc   = 0;
        m_sc   = 0;
        m_cnt  = 0;
        for (int i = 0; i < 16; i++) m_lut[i] = 0;
    endfunction

    function automatic void model_step();
        int flag;
        if (m_mode == 0) begin
            if (bus.lut_we) m_lut[bus.lut_addr] = int'(bus.lut_data);
            if (bus.start) begin
                m_mode = 1;
                m_pc   = 0;
                m_cnt  = 0;
            end
        end else if (m_mode == 1) begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (bus.sc_wr) m_sc = int'(bus.sc_o);
            flag = bus.br_type ? int'(bus.lessthan) : int'(bus.notequal);
            if (bus.halt) m_mode = 2;
            else if (bus.br_en && flag == 1) m_pc = m_lut[bus.target_idx];
            else m_pc = (m_pc + 1) % 1024;
        end else begin
            if (bus.start) begin
                m_mode = 1;
                m_pc   = 0;
                m_cnt  = 0;
            end
        end
    endfunction

    function automatic int exp_count();
`ifdef PC_CYCLE_COUNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_pc"},      32'(bus.prog_ctr),    32'(m_pc));
        check({tag, "_sc"},      32'(bus.sc_in),       32'(m_sc));
        check({tag, "_running"}, 32'(bus.running),     32'(m_mode == 1));
        check({tag, "_done"},    32'(bus.done),        32'(m_mode == 2));
        check({tag, "_cnt"},     32'(bus.cycle_count), 32'(exp_count()));
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.start      = 1'b0;
        bus.halt       = 1'b0;
        bus.br_en      = 1'b0;
        bus.br_type    = 1'b0;
        bus.notequal   = 1'b0;
        bus.lessthan   = 1'b0;
        bus.target_idx = '0;
        bus.sc_wr      = 1'b0;
        bus.sc_o       = 1'b0;
        bus.lut_we     = 1'b0;
        bus.lut_addr   = '0;
        bus.lut_data   = '0;
    endtask

    // Advance one edge with the currently driven inputs
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       start, halt, br_en, br_type, ne, lt;
        logic [3:0] idx;
        logic       sc_wr, sc_o, lut_we;
        logic [3:0] lut_addr;
        logic [9:0] lut_data;
        logic [9:0] exp_pc;
        logic       exp_sc, exp_run, exp_done;
    } vec_t;

    vec_t vecs [29];

    function automatic vec_t mk(
        input logic st, input logic h, input logic be, input logic bt,
        input logic ne, input logic lt, input logic [3:0] idx,
        input logic sw, input logic so, input logic lw,
        input logic [3:0] la, input logic [9:0] ld,
        input logic [9:0] epc, input logic esc, input logic er, input logic ed);
        vec_t v;
        v.start = st; v.halt = h; v.br_en = be; v.br_type = bt;
        v.ne = ne; v.lt = lt; v.idx = idx; v.sc_wr = sw; v.sc_o = so;
        v.lut_we = lw; v.lut_addr = la; v.lut_data = ld;
        v.exp_pc = epc; v.exp_sc = esc; v.exp_run = er; v.exp_done = ed;
        return v;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;

        //               st h be bt ne lt idx sw so lw la ld   pc   sc r d
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0,   0, 1, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    1,   0, 1, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    2,   0, 1, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    3,   0, 1, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    4,   0, 1, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    5,   0, 1, 0);
        vecs[6]  = mk(0, 0, 1, 0, 1, 0, 3, 0, 0, 0, 0, 0,  200,   0, 1, 0);
        vecs[7]  = mk(0, 0, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0,  201,   0, 1, 0);
        vecs[8]  = mk(0, 0, 1, 1, 0, 1, 5, 0, 0, 0, 0, 0,  777,   0, 1, 0);
        vecs[9]  = mk(0, 0, 1, 1, 1, 0, 5, 0, 0, 0, 0, 0,  778,   0, 1, 0);
        vecs[10] = mk(0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 0,  779,   0, 1, 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,  780,   1, 1, 0);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  781,   1, 1, 0);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  782,   1, 1, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  783,   1, 1, 0);
        vecs[15] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  784,   1, 1, 0);
        vecs[16] = mk(0, 1, 1, 0, 1, 0, 3, 0, 0, 0, 0, 0,  784,   1, 0, 1);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  784,   1, 0, 1);
        vecs[18] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0,   1, 1, 0);
        vecs[19] = mk(0, 0, 1, 1, 0, 1, 7, 0, 0, 0, 0, 0, 1022,   1, 1, 0);
        vecs[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1023,   1, 1, 0);
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0,   1, 1, 0);
        vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,    1,   0, 1, 0);
        vecs[23] = mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,    1,   1, 0, 1);
        vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 5,    1,   1, 0, 1);
        vecs[25] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0,   1, 1, 0);
        vecs[26] = mk(0, 0, 1, 0, 1, 0, 3, 0, 0, 0, 0, 0,  200,   1, 1, 0);
        vecs[27] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 9,  201,   1, 1, 0);
        vecs[28] = mk(0, 0, 1, 0, 1, 0, 3, 0, 0, 0, 0, 0,  200,   1, 1, 0);

        // ---------------- reset ----------------
        idle_inputs();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc",      32'(bus.prog_ctr),    32'd0);
        check("rst_sc",      32'(bus.sc_in),       32'd0);
        check("rst_running", 32'(bus.running),     32'd0);
        check("rst_done",    32'(bus.done),        32'd0);
        check("rst_cnt",     32'(bus.cycle_count), 32'd0);
        check("rst_state",   32'(bus.state_dbg),   32'(IDLE));
        reset = 1'b0;

        // ---------------- load the table in IDLE ----------------
        bus.lut_we = 1'b1;
        bus.lut_addr = 4'd3; bus.lut_data = 10'd200;  tick();
        bus.lut_addr = 4'd5; bus.lut_data = 10'd777;  tick();
        bus.lut_addr = 4'd7; bus.lut_data = 10'd1022; tick();
        idle_inputs();
        check_model("idle_load");

        // ---------------- directed vector table ----------------
        for (int i = 0; i < 29; i++) begin
            bus.start      = vecs[i].start;
            bus.halt       = vecs[i].halt;
            bus.br_en      = vecs[i].br_en;
            bus.br_type    = vecs[i].br_type;
            bus.notequal   = vecs[i].ne;
            bus.lessthan   = vecs[i].lt;
            bus.target_idx = vecs[i].idx;
            bus.sc_wr      = vecs[i].sc_wr;
            bus.sc_o       = vecs[i].sc_o;
            bus.lut_we     = vecs[i].lut_we;
            bus.lut_addr   = vecs[i].lut_addr;
            bus.lut_data   = vecs[i].lut_data;
            tick();
            check($sformatf("vec%0d_pc", i),      32'(bus.prog_ctr),    32'(vecs[i].exp_pc));
            check($sformatf("vec%0d_sc", i),      32'(bus.sc_in),       32'(vecs[i].exp_sc));
            check($sformatf("vec%0d_running", i), 32'(bus.running),     32'(vecs[i].exp_run));
            check($sformatf("vec%0d_done", i),    32'(bus.done),        32'(vecs[i].exp_done));
            check($sformatf("vec%0d_cnt", i),     32'(bus.cycle_count), 32'(exp_count()));
        end
        idle_inputs();

        // ---------------- cycle counter sequence ----------------
        bus.halt = 1'b1; tick(); bus.halt = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("cnt_start_clear", 32'(bus.cycle_count), 32'd0);
        repeat (7) tick();
        bus.halt = 1'b1; tick(); bus.halt = 1'b0;
`ifdef PC_CYCLE_COUNT_EN
        check("cnt_after_halt", 32'(bus.cycle_count), 32'd8);
`else
        check("cnt_after_halt", 32'(bus.cycle_count), 32'd0);
`endif
        check("cnt_halt_done", 32'(bus.done), 32'd1);
        repeat (2) tick();
        check_model("cnt_hold");

        // ---------------- asynchronous reset mid-RUN ----------------
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        repeat (2) tick();
        check_model("pre_rst");
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_model("async_rst");
        check("async_rst_state", 32'(bus.state_dbg), 32'(IDLE));
        #1;
        reset = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        bus.br_en = 1'b1; bus.br_type = BR_NEQ; bus.notequal = 1'b1; bus.target_idx = 4'd3;
        tick();
        idle_inputs();
        check("lut_cleared_pc", 32'(bus.prog_ctr), 32'd0);
        check_model("post_rst");

        // ---------------- randomized phase ----------------
        for (int n = 0; n < 400; n++) begin
            bus.start      = ($urandom_range(0, 5) == 0);
            bus.halt       = ($urandom_range(0, 15) == 0);
            bus.br_en      = $urandom_range(0, 1);
            bus.br_type    = $urandom_range(0, 1);
            bus.notequal   = $urandom_range(0, 1);
            bus.lessthan   = $urandom_range(0, 1);
            bus.target_idx = 4'($urandom_range(0, 15));
            bus.sc_wr      = ($urandom_range(0, 2) == 0);
            bus.sc_o       = $urandom_range(0, 1);
            bus.lut_we     = ($urandom_range(0, 3) == 0);
            bus.lut_addr   = 4'($urandom_range(0, 15));
            bus.lut_data   = 10'($urandom_range(0, 1023));
            tick();
            check_model($sformatf("rnd%0d", n));
        end
        idle_inputs();

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
